// File: rtl/reset_seq_pkg.sv
// Shared types and elaboration-time helpers for the reset sequencer.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } seq_state_e;

  // Ceiling log2, used to size counters so they can hold their terminal value.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < value) r = r + 1;
    end
    return r;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // True when every parameter lies in its legal range.
  function automatic bit params_ok(input int sync_stages, input int debounce_cycles,
                                   input int num_domains, input int stretch_cycles,
                                   input int stagger_cycles);
    return (sync_stages >= 2) && (debounce_cycles >= 1) &&
           (num_domains >= 1) && (num_domains <= 8) &&
           (stretch_cycles >= 1) && (stagger_cycles >= 1);
  endfunction

endpackage

// File: rtl/btn_debouncer.sv
// Synchronises the raw push-button into the clock domain and debounces it,
// emitting a single-cycle pulse on each accepted rising level.
module btn_debouncer
  import reset_seq_pkg::*;
#(
  parameter int SYNC_STAGES     = 3,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic stable_o,
  output logic rise_pulse_o
);

  localparam int CW = clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   btn_sync;
  logic                   stable_q, stable_d;
  logic                   rise_q, rise_d;
  logic [CW-1:0]          cnt_q, cnt_d;

  assign btn_sync     = sync_q[SYNC_STAGES-1];
  assign stable_o     = stable_q;
  assign rise_pulse_o = rise_q;

  // Shift the asynchronous button through the synchroniser chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], btn_i};
  end

  // Accept a new level only after it has differed from the stable level long enough.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    rise_d   = 1'b0;
    if (btn_sync == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_d = ~stable_q;
      cnt_d    = '0;
      rise_d   = ~stable_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable_q <= 1'b0;
      cnt_q    <= '0;
      rise_q   <= 1'b0;
    end else begin
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      rise_q   <= rise_d;
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// Top-level reset sequencer: stretches any reset trigger and then releases
// the domain resets one by one, bit 0 first, at fixed intervals.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int SYNC_STAGES     = 3,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int NUM_DOMAINS     = 3,
  parameter int STRETCH_CYCLES  = 4,
  parameter int STAGGER_CYCLES  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   btn_in,
  input  logic                   sw_rst_req,
  input  logic                   hold,
  output logic [NUM_DOMAINS-1:0] rst_out,
  output logic                   btn_event,
  output logic                   busy
);

  localparam int CW = clog2(max2(STRETCH_CYCLES, STAGGER_CYCLES) + 1);
  localparam int IW = clog2(NUM_DOMAINS + 1);
  localparam logic [CW-1:0] STRETCH_LAST = CW'(STRETCH_CYCLES - 1);
  localparam logic [CW-1:0] STAGGER_LAST = CW'(STAGGER_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST     = IW'(NUM_DOMAINS - 1);
  localparam logic [NUM_DOMAINS-1:0] ONE_BIT = NUM_DOMAINS'(1);

  // Refuse to elaborate with out-of-range parameters.
  if (!params_ok(SYNC_STAGES, DEBOUNCE_CYCLES, NUM_DOMAINS, STRETCH_CYCLES, STAGGER_CYCLES)) begin : g_bad_params
    $error("reset_sequencer: illegal parameter combination");
  end

  seq_state_e             state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [NUM_DOMAINS-1:0] rst_out_q, rst_out_d;
  logic                   busy_q, busy_d;
  logic                   btn_stable;
  logic                   trigger;

  btn_debouncer #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk         (clk),
    .rst         (rst),
    .btn_i       (btn_in),
    .stable_o    (btn_stable),
    .rise_pulse_o(btn_event)
  );

  assign trigger = btn_event | sw_rst_req;
  assign rst_out = rst_out_q;
  assign busy    = busy_q;

  // Next-state logic: a trigger or hold always wins over a scheduled release.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    rst_out_d = rst_out_q;
    case (state_q)
      ST_ASSERT: begin
        rst_out_d = '1;
        if (trigger || hold) begin
          cnt_d = '0;
        end else if (cnt_q == STRETCH_LAST) begin
          rst_out_d[0] = 1'b0;
          idx_d        = IW'(1);
          cnt_d        = '0;
          state_d      = (NUM_DOMAINS == 1) ? ST_RUN : ST_RELEASE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RELEASE: begin
        if (trigger || hold) begin
          rst_out_d = '1;
          cnt_d     = '0;
          idx_d     = '0;
          state_d   = ST_ASSERT;
        end else if (cnt_q == STAGGER_LAST) begin
          rst_out_d = rst_out_q & ~(ONE_BIT << idx_q);
          idx_d     = idx_q + 1'b1;
          cnt_d     = '0;
          if (idx_q == IDX_LAST) state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        rst_out_d = '0;
        if (trigger || hold) begin
          rst_out_d = '1;
          cnt_d     = '0;
          idx_d     = '0;
          state_d   = ST_ASSERT;
        end
      end
      default: begin
        rst_out_d = '1;
        cnt_d     = '0;
        idx_d     = '0;
        state_d   = ST_ASSERT;
      end
    endcase
    busy_d = |rst_out_d;
  end

  // Sequencer registers; outputs come straight from flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_ASSERT;
      cnt_q     <= '0;
      idx_q     <= '0;
      rst_out_q <= '1;
      busy_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      rst_out_q <= rst_out_d;
      busy_q    <= busy_d;
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with default parameters.
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_in;
  logic       sw_rst_req;
  logic       hold;
  logic [2:0] rst_out;
  logic       btn_event;
  logic       busy;

  int compareCount = 0;
  int failCount    = 0;
  int edgeNum      = 0;

  // 10 ns clock.
  always #5 clk = ~clk;

  reset_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .btn_in    (btn_in),
    .sw_rst_req(sw_rst_req),
    .hold      (hold),
    .rst_out   (rst_out),
    .btn_event (btn_event),
    .busy      (busy)
  );

  // One comparison: count it, and report tag/observed/expected on a miss.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compareCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h (edge %0d)", tag, observed, expected, edgeNum);
    end
  endtask

  // Drive the inputs, advance one rising edge, and settle 1 ns past it.
  task automatic applyStimulus(input logic b, input logic s, input logic h);
    btn_in     = b;
    sw_rst_req = s;
    hold       = h;
    @(posedge clk);
    edgeNum++;
    #1;
  endtask

  // Hand-derived release pattern for 4-cycle stretch and 8-cycle stagger,
  // where base is the last edge on which the stretch counter was cleared.
  function automatic logic [2:0] expRst(input int e, input int base);
    int k;
    k = e - base;
    if (k < 4)  return 3'b111;
    if (k < 12) return 3'b110;
    if (k < 20) return 3'b100;
    return 3'b000;
  endfunction

  // Compare rst_out and busy against the release pattern.
  task automatic checkSeq(input string tag, input int base);
    logic [2:0] e;
    e = expRst(edgeNum, base);
    checkOutput({tag, "_rst_out"}, rst_out, e);
    checkOutput({tag, "_busy"}, busy, (e != 3'b000));
  endtask

  // Hold async reset for two edges, check the reset state, then release it.
  task automatic doReset(input logic h);
    rst        = 1'b1;
    btn_in     = 1'b0;
    sw_rst_req = 1'b0;
    hold       = h;
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("in_reset_rst_out", rst_out, 3'b111);
    checkOutput("in_reset_busy", busy, 1'b1);
    checkOutput("in_reset_btn_event", btn_event, 1'b0);
    rst     = 1'b0;
    edgeNum = 0;
  endtask

  // Linear sequence of directed scenarios.
  initial begin
    logic b;
    int   events;
    int   delay;
    int   startEdge;
    int   eventEdge;

    // Power-up release order with no hold.
    doReset(1'b0);
    for (int i = 0; i < 24; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkSeq("pwrup", 0);
    end

    // Hold keeps everything in reset until it drops after edge 30.
    doReset(1'b1);
    for (int i = 0; i < 30; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("hold_rst_out", rst_out, 3'b111);
    end
    for (int i = 0; i < 22; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkSeq("hold_rel", 30);
    end

    // Software request on the edge domain 1 would have been released.
    doReset(1'b0);
    for (int i = 0; i < 11; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkSeq("sw_pre", 0);
    end
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("sw_collide_rst_out", rst_out, 3'b111);
    for (int i = 0; i < 22; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkSeq("sw_restart", 12);
    end

    // Repeated requests during the stretch restart it.
    doReset(1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("retrig_e5_rst_out", rst_out, 3'b111);
    for (int i = 0; i < 22; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkSeq("retrig", 5);
    end

    // Bouncing button while running: no event, no reset.
    b      = 1'b0;
    events = 0;
    for (int t = 0; t < 60; t++) begin
      if (t % 5 == 0) b = ~b;
      applyStimulus(b, 1'b0, 1'b0);
      if (btn_event === 1'b1) events++;
    end
    checkOutput("bounce_events", events, 0);
    checkOutput("bounce_rst_out", rst_out, 3'b000);

    // Clean press: one event after synchroniser plus debounce latency.
    startEdge = edgeNum;
    delay     = -1;
    for (int t = 0; t < 40; t++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      if (btn_event === 1'b1) begin
        delay = edgeNum - startEdge;
        break;
      end
    end
    checkOutput("press_latency", delay, 19);
    eventEdge = edgeNum;
    events    = 0;
    for (int i = 0; i < 24; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      if (btn_event === 1'b1) events++;
      checkSeq("press_seq", eventEdge + 1);
    end
    checkOutput("press_single_event", events, 0);

    // Debounced release of the button gives no event and no reset.
    events = 0;
    for (int i = 0; i < 30; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      if (btn_event === 1'b1) events++;
    end
    checkOutput("fall_events", events, 0);
    checkOutput("fall_rst_out", rst_out, 3'b000);

    // Async reset mid-release acts without a clock edge.
    doReset(1'b0);
    for (int i = 0; i < 13; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkSeq("async_pre", 0);
    end
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_out", rst_out, 3'b111);
    checkOutput("async_busy", busy, 1'b1);
    checkOutput("async_btn_event", btn_event, 1'b0);
    #2;
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
